operand_sel_stage: RTL and testbench
====================================

OPERAND_SEL_STAGE -- requirements
Module: operand_sel_stage

Interface
REQ-001 Parameter WIDTH, default 32, data width of each input and of the output.
REQ-002 Parameter NUM_IN, default 3, number of selectable inputs; legal range 2..8.
REQ-003 Parameter SEL_W, default $clog2(NUM_IN), select field width.
REQ-004 Port clk  input  1  rising-edge clock, single clock domain.
REQ-005 Port rst  input  1  synchronous, active-high reset.
REQ-006 Port in_valid  input  1  producer presents a beat.
REQ-007 Port in_ready  output  1  stage accepts a beat this cycle.
REQ-008 Port sel  input  SEL_W  input index to forward; qualified by in_valid.
REQ-009 Port data_in  input  NUM_IN*WIDTH  flattened inputs; input k at bits [k*WIDTH +: WIDTH].
REQ-010 Port flush  input  1  discard all buffered beats.
REQ-011 Port out_valid  output  1  output beat present.
REQ-012 Port out_ready  input  1  consumer accepts output beat.
REQ-013 Port data_out  output  WIDTH  selected value of the head beat.
REQ-014 Port sel_err  output  1  head beat carried an out-of-range sel.
REQ-015 Port err_count  output  8  saturating count of accepted out-of-range beats.

Function
REQ-016 Accept when in_valid && in_ready; emit when out_valid && out_ready.
REQ-017 Selection and hold-last-value are evaluated at acceptance and registered; data_out and sel_err shall come only from registers, never combinationally from data_in/sel.
REQ-018 Latency: a beat accepted in cycle N shall appear on out_valid/data_out in cycle N+1 when the stage was empty.
REQ-019 Storage is a 2-entry skid buffer with states EMPTY, ONE (head valid, skid empty), FULL (head and skid valid).
REQ-020 in_ready = (state != FULL), a registered-state decode, independent of out_ready in the same cycle.
REQ-021 EMPTY: accept -> ONE; otherwise stay.
REQ-022 ONE: accept and emit -> ONE, new beat becomes head; accept only -> FULL, new beat into skid; emit only -> EMPTY; neither -> stay.
REQ-023 FULL: emit -> ONE, skid moves to head; no accept possible.
REQ-024 Beat ordering is strictly FIFO; no beat shall be duplicated or dropped except by flush or rst.
REQ-025 Valid sel (sel < NUM_IN): beat value = data_in slice sel; last_good register updated to that value; beat sel_err = 0.
REQ-026 Out-of-range sel (sel >= NUM_IN, possible only when NUM_IN is not a power of 2): beat value = current last_good; last_good unchanged; beat sel_err = 1; err_count increments by 1.
REQ-027 err_count saturates at 255 and shall not wrap.
REQ-028 Head data/sel_err registers shall hold their value while out_valid && !out_ready.
REQ-029 flush: next state EMPTY, both entries invalidated; any beat offered in the flush cycle shall not be accepted, and last_good/err_count shall not be updated by it; last_good and err_count otherwise keep their values.
REQ-030 rst has priority over flush; flush has priority over accept/emit.

Reset
REQ-031 On rst: state EMPTY, out_valid 0, in_ready 1 in the following cycle, data_out 0, sel_err 0, last_good 0, err_count 0, skid contents 0.
REQ-032 rst asserted mid-transfer shall discard buffered beats without emitting them.

Structure
REQ-033 State encoding (EMPTY/ONE/FULL) and the err_count width constant (8) shall live in the shared cpu_pkg package.
REQ-034 The skid buffer shall be a sub-module named skid_buf2, parametrised by WIDTH+1 (value plus sel_err); selection, last_good and err_count logic stay in operand_sel_stage.
REQ-035 The block shall be synthesisable with no latches and no combinational path from in_valid/sel/data_in to any output.

Verification
REQ-036 NUM_IN=3, inputs {0x11,0x22,0x33}, sel=2, out_ready=1 -> data_out=0x33, out_valid one cycle after accept, sel_err=0.
REQ-037 sel=1 (0x22) accepted, then sel=3 -> second beat data_out=0x22, sel_err=1, err_count=1.
REQ-038 out_ready=0, three beats sel=0,1,2 offered back-to-back -> first two accepted, in_ready=0 while FULL; release out_ready -> outputs 0x11,0x22 then 0x33 in order, no loss.
REQ-039 FULL state, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, flushed and offered beats never emitted.
REQ-040 260 out-of-range beats -> err_count=255, no wrap; rst -> err_count=0, data_out=0, last_good=0.
REQ-041 Random in_valid/out_ready over 10k beats, NUM_IN=5, WIDTH=16 -> output stream equals reference model stream in order.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the operand select stage.
// Holds the skid buffer state encoding and error counter width.
package cpu_pkg;

  localparam int ERR_W = 8;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } buf_state_t;

endpackage

// File: rtl/skid_buf2.sv
// Two-entry skid buffer: head drives the output, skid absorbs one beat.
// Ready depends only on the registered state.
module skid_buf2
  import cpu_pkg::*;
#(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] din,
  output logic         ready,
  output logic         valid,
  input  logic         pop,
  output logic [W-1:0] dout
);

  buf_state_t   state;
  logic [W-1:0] head;
  logic [W-1:0] skid;

  assign ready = (state != FULL);
  assign valid = (state != EMPTY);
  assign dout  = head;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
      head  <= '0;
      skid  <= '0;
    end else if (flush) begin
      state <= EMPTY;
    end else begin
      unique case (state)
        EMPTY: begin
          if (push) begin
            head  <= din;
            state <= ONE;
          end
        end
        ONE: begin
          if (push && pop) begin
            head <= din;
          end else if (push) begin
            skid  <= din;
            state <= FULL;
          end else if (pop) begin
            state <= EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            head  <= skid;
            state <= ONE;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule

// File: rtl/operand_sel_stage.sv
// Operand select stage: picks one of NUM_IN inputs per beat, falls back
// to the last good value on an out-of-range select, buffers in skid_buf2.
module operand_sel_stage
  import cpu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 3,
  parameter int SEL_W  = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [SEL_W-1:0]        sel,
  input  logic [NUM_IN*WIDTH-1:0] data_in,
  input  logic                    flush,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        data_out,
  output logic                    sel_err,
  output logic [ERR_W-1:0]        err_count
);

  logic             accept;
  logic             emit;
  logic             sel_ok;
  logic [WIDTH-1:0] pick;
  logic [WIDTH-1:0] last_good;
  logic [WIDTH:0]   beat;
  logic             buf_ready;

  assign in_ready = buf_ready;
  assign accept   = in_valid && buf_ready && !flush;
  assign emit     = out_valid && out_ready;
  assign sel_ok   = 32'(sel) < 32'(NUM_IN);

  always_comb begin
    pick = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (sel == SEL_W'(k)) pick = data_in[k*WIDTH +: WIDTH];
    end
  end

  assign beat = sel_ok ? {1'b0, pick} : {1'b1, last_good};

  always_ff @(posedge clk) begin
    if (rst) begin
      last_good <= '0;
      err_count <= '0;
    end else if (accept) begin
      if (sel_ok) begin
        last_good <= pick;
      end else if (err_count != {ERR_W{1'b1}}) begin
        err_count <= err_count + 1'b1;
      end
    end
  end

  skid_buf2 #(
    .W(WIDTH + 1)
  ) u_buf (
    .clk  (clk),
    .rst  (rst),
    .flush(flush),
    .push (accept),
    .din  (beat),
    .ready(buf_ready),
    .valid(out_valid),
    .pop  (emit),
    .dout ({sel_err, data_out})
  );

endmodule

// File: tb/tb_operand_sel_stage.sv
// Directed and randomised checks of operand_sel_stage.
// Two instances: NUM_IN=3/WIDTH=32 and NUM_IN=5/WIDTH=16.
module tb_operand_sel_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, in_ready, flush;
  logic        out_valid, out_ready, sel_err;
  logic [1:0]  sel;
  logic [95:0] data_in;
  logic [31:0] data_out;
  logic [7:0]  err_count;

  logic        b_rst, b_in_valid, b_in_ready, b_flush;
  logic        b_out_valid, b_out_ready, b_sel_err;
  logic [2:0]  b_sel;
  logic [79:0] b_data_in;
  logic [15:0] b_data_out;
  logic [7:0]  b_err_count;

  int n_cmp = 0;
  int n_bad = 0;

  operand_sel_stage #(.WIDTH(32), .NUM_IN(3)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .sel(sel), .data_in(data_in), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .data_out(data_out), .sel_err(sel_err), .err_count(err_count)
  );

  operand_sel_stage #(.WIDTH(16), .NUM_IN(5)) dut_b (
    .clk(clk), .rst(b_rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .sel(b_sel), .data_in(b_data_in), .flush(b_flush),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .data_out(b_data_out), .sel_err(b_sel_err), .err_count(b_err_count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1; in_valid = 0; flush = 0; out_ready = 0; sel = 0;
    data_in = {32'h33, 32'h22, 32'h11};
    step(); step();
    rst = 0;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++;
      $display("FAIL rst_out_valid got %b want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++;
      $display("FAIL rst_in_ready got %b want 1", in_ready); end
    n_cmp++; if (data_out !== 32'h0) begin n_bad++;
      $display("FAIL rst_data got %h want 0", data_out); end
    n_cmp++; if (sel_err !== 1'b0) begin n_bad++;
      $display("FAIL rst_sel_err got %b want 0", sel_err); end
    n_cmp++; if (err_count !== 8'd0) begin n_bad++;
      $display("FAIL rst_err_count got %0d want 0", err_count); end
  endtask

  task automatic test_select();
    in_valid = 1; sel = 2; out_ready = 1;
    step();
    in_valid = 0;
    n_cmp++; if (out_valid !== 1'b1 || data_out !== 32'h33) begin n_bad++;
      $display("FAIL sel2 got v=%b %h want v=1 33", out_valid, data_out); end
    n_cmp++; if (sel_err !== 1'b0) begin n_bad++;
      $display("FAIL sel2_err got %b want 0", sel_err); end
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++;
      $display("FAIL sel2_drain got %b want 0", out_valid); end
  endtask

  task automatic test_oob();
    in_valid = 1; sel = 1; out_ready = 1;
    step();
    n_cmp++; if (data_out !== 32'h22 || sel_err !== 1'b0) begin n_bad++;
      $display("FAIL sel1 got %h e=%b want 22 e=0", data_out, sel_err); end
    sel = 3;
    step();
    in_valid = 0;
    n_cmp++; if (data_out !== 32'h22 || sel_err !== 1'b1) begin n_bad++;
      $display("FAIL oob got %h e=%b want 22 e=1", data_out, sel_err); end
    n_cmp++; if (err_count !== 8'd1) begin n_bad++;
      $display("FAIL oob_cnt got %0d want 1", err_count); end
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++;
      $display("FAIL oob_drain got %b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    out_ready = 0; in_valid = 1; sel = 0;
    step();
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++;
      $display("FAIL b2b_one_ready got %b want 1", in_ready); end
    sel = 1;
    step();
    sel = 2;
    n_cmp++; if (in_ready !== 1'b0 || data_out !== 32'h11) begin n_bad++;
      $display("FAIL b2b_full got r=%b %h want r=0 11", in_ready, data_out); end
    step();
    n_cmp++; if (in_ready !== 1'b0 || data_out !== 32'h11 || out_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_hold got r=%b v=%b %h want r=0 v=1 11",
               in_ready, out_valid, data_out); end
    out_ready = 1;
    step();
    n_cmp++; if (data_out !== 32'h22 || in_ready !== 1'b1) begin n_bad++;
      $display("FAIL b2b_second got %h r=%b want 22 r=1", data_out, in_ready); end
    step();
    in_valid = 0;
    n_cmp++; if (data_out !== 32'h33 || out_valid !== 1'b1) begin n_bad++;
      $display("FAIL b2b_third got v=%b %h want v=1 33", out_valid, data_out); end
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++;
      $display("FAIL b2b_drain got %b want 0", out_valid); end
  endtask

  task automatic test_flush();
    out_ready = 0; in_valid = 1; sel = 0;
    step();
    sel = 1;
    step();
    flush = 1; sel = 2;
    step();
    flush = 0; in_valid = 0;
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_bad++;
      $display("FAIL flush_full got v=%b r=%b want v=0 r=1", out_valid, in_ready); end
    out_ready = 1;
    step(); step();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++;
      $display("FAIL flush_ghost got %b want 0", out_valid); end
    // last_good becomes 0x22 here; the flushed sel=2 beat must not move it
    out_ready = 0; in_valid = 1; sel = 1;
    step();
    flush = 1; sel = 2;
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++;
      $display("FAIL flush_one got %b want 0", out_valid); end
    sel = 3;
    step();
    flush = 0; in_valid = 0;
    n_cmp++; if (err_count !== 8'd1 || out_valid !== 1'b0) begin n_bad++;
      $display("FAIL flush_cnt got %0d v=%b want 1 v=0", err_count, out_valid); end
    out_ready = 1; in_valid = 1; sel = 3;
    step();
    in_valid = 0;
    n_cmp++; if (data_out !== 32'h22 || sel_err !== 1'b1 || err_count !== 8'd2) begin
      n_bad++;
      $display("FAIL flush_lastgood got %h e=%b c=%0d want 22 e=1 c=2",
               data_out, sel_err, err_count); end
    step();
  endtask

  task automatic test_saturate();
    out_ready = 1; in_valid = 1; sel = 3;
    repeat (260) step();
    n_cmp++; if (err_count !== 8'd255) begin n_bad++;
      $display("FAIL sat got %0d want 255", err_count); end
    in_valid = 0; rst = 1;
    step();
    rst = 0;
    n_cmp++; if (err_count !== 8'd0 || data_out !== 32'h0 || out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL sat_rst got c=%0d %h v=%b want 0 0 0",
               err_count, data_out, out_valid); end
    in_valid = 1; sel = 3;
    step();
    in_valid = 0;
    n_cmp++; if (data_out !== 32'h0 || sel_err !== 1'b1 || err_count !== 8'd1) begin
      n_bad++;
      $display("FAIL rst_lastgood got %h e=%b c=%0d want 0 e=1 c=1",
               data_out, sel_err, err_count); end
    step();
  endtask

  task automatic test_random();
    logic [16:0] exp_q[$];
    logic [16:0] exp;
    logic [15:0] lg;
    logic [95:0] tmp;
    int beats, cyc, ecnt, shown;
    lg = '0; beats = 0; cyc = 0; ecnt = 0; shown = 0;
    b_in_valid = 0; b_out_ready = 0; b_flush = 0; b_sel = 0; b_data_in = '0;
    b_rst = 1;
    step(); step();
    b_rst = 0;
    while ((beats < 10000 || exp_q.size() != 0) && cyc < 60000) begin
      b_in_valid = (beats < 10000) && ($urandom_range(0, 3) != 0);
      b_out_ready = ($urandom_range(0, 3) != 0);
      b_sel = 3'($urandom_range(0, 7));
      tmp = {$urandom, $urandom, $urandom};
      b_data_in = tmp[79:0];
      if (b_out_valid && b_out_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL rand_extra got %h e=%b want nothing", b_data_out, b_sel_err);
        end else begin
          exp = exp_q.pop_front();
          if ({b_sel_err, b_data_out} !== exp) begin
            n_bad++;
            if (shown < 10)
              $display("FAIL rand_beat got %h want %h", {b_sel_err, b_data_out}, exp);
            shown++;
          end
        end
      end
      if (b_in_valid && b_in_ready) begin
        if (b_sel < 3'd5) begin
          lg = b_data_in[int'(b_sel)*16 +: 16];
          exp_q.push_back({1'b0, lg});
        end else begin
          exp_q.push_back({1'b1, lg});
          if (ecnt < 255) ecnt++;
        end
        beats++;
      end
      step();
      cyc++;
    end
    b_in_valid = 0;
    n_cmp++; if (beats != 10000 || exp_q.size() != 0) begin n_bad++;
      $display("FAIL rand_timeout got beats=%0d left=%0d want 10000 0",
               beats, exp_q.size()); end
    n_cmp++; if (b_err_count !== 8'(ecnt)) begin n_bad++;
      $display("FAIL rand_cnt got %0d want %0d", b_err_count, ecnt); end
  endtask

  initial begin
    b_rst = 1; b_in_valid = 0; b_out_ready = 0; b_flush = 0;
    b_sel = 0; b_data_in = '0;
    test_reset();
    test_select();
    test_oob();
    test_back_to_back();
    test_flush();
    test_saturate();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
